// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
package imem_pkg;

    localparam int IMEM_DEPTH = 1024;
    localparam int IMEM_IDX_W = $clog2(IMEM_DEPTH);

    typedef enum logic {
        IMEM_LOAD,
        IMEM_SERVE
    } imem_state_t;

    // Word returned for misaligned or out-of-range fetches.
    localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// Instruction store: one synchronous write port and one registered read port.
// The storage and the read register have no reset.
module imem_ram #(
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: the word lands on the write-enable edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: rdata only changes when re is high, so it holds a response.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a program image over the load port,
// then serves byte-addressed fetches with a one-cycle registered response.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [IDX_W-1:0] ld_addr,
    input  logic [31:0]      ld_data,
    input  logic             ld_last,
    output logic [IDX_W:0]   ld_cnt,
    output logic             boot_done,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_err
);

    localparam logic [IDX_W:0] CNT_MAX = (IDX_W + 1)'(DEPTH);

    imem_state_t       state_q;
    imem_state_t       state_d;
    logic [IDX_W:0]    ld_cnt_q;
    logic              ld_we;
    logic              accept;
    logic [IDX_W-1:0]  req_idx;
    logic              req_err;
    logic [31:0]       ram_rdata;

    // Response-stage control; data_ok_p1 marks that ram_rdata holds a valid word.
    logic              rsp_vld_p1;
    logic              rsp_err_p1;
    logic              data_ok_p1;

    // Request decode: word index and alignment/range error.
    always_comb begin
        req_idx = req_addr[IDX_W+1:2];
        req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:IDX_W+2] != '0);
    end

    // Next-state and handshake outputs; ready signals come straight from state.
    always_comb begin
        state_d   = state_q;
        ld_ready  = 1'b0;
        boot_done = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            IMEM_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid && ld_last) begin
                    state_d = IMEM_SERVE;
                end
            end
            IMEM_SERVE: begin
                boot_done = 1'b1;
                req_ready = !rsp_vld_p1 || rsp_ready;
            end
            default: begin
                state_d = IMEM_LOAD;
            end
        endcase
    end

    assign ld_we  = ld_valid && ld_ready;
    assign accept = req_valid && req_ready;

    // State register; reset returns to LOAD regardless of progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IMEM_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Load word counter, saturating at DEPTH; rewrites of an index still count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_cnt_q <= '0;
        end else if (ld_we && (ld_cnt_q != CNT_MAX)) begin
            ld_cnt_q <= ld_cnt_q + 1'b1;
        end
    end

    // ---- stage p1: response register, loaded on accept, held under backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_vld_p1 <= 1'b0;
            rsp_err_p1 <= 1'b0;
            data_ok_p1 <= 1'b0;
        end else if (accept) begin
            rsp_vld_p1 <= 1'b1;
            rsp_err_p1 <= req_err;
            data_ok_p1 <= !req_err;
        end else if (rsp_vld_p1 && rsp_ready) begin
            rsp_vld_p1 <= 1'b0;
        end
    end

    // Read enable doubles as the hold: the RAM read register only moves on accept.
    imem_ram #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .DATA_W (32)
    ) u_ram (
        .clk   (clk),
        .we    (ld_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (accept),
        .raddr (req_idx),
        .rdata (ram_rdata)
    );

    assign ld_cnt    = ld_cnt_q;
    assign rsp_valid = rsp_vld_p1;
    assign rsp_err   = rsp_err_p1;
    assign rsp_data  = data_ok_p1 ? ram_rdata : IMEM_NOP;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus randomized
// load/fetch traffic compared against a behavioural model of the responder.
module tb_imem_responder;
    import imem_pkg::*;

    localparam int DEPTH = IMEM_DEPTH;
    localparam int IDX_W = IMEM_IDX_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             ld_valid;
    logic             ld_ready;
    logic [IDX_W-1:0] ld_addr;
    logic [31:0]      ld_data;
    logic             ld_last;
    logic [IDX_W:0]   ld_cnt;
    logic             boot_done;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;

    imem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_cnt    (ld_cnt),
        .boot_done (boot_done),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: loading flag, word count, pending response, image.
    bit          m_load;
    int          m_cnt;
    bit          m_rv;
    bit          m_re;
    bit          m_rdk;
    logic [31:0] m_rd;
    logic [31:0] m_mem [DEPTH];
    bit          m_kn  [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_load = 1'b1;
        m_cnt  = 0;
        m_rv   = 1'b0;
        m_re   = 1'b0;
        m_rd   = 32'h0;
        m_rdk  = 1'b1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".ld_ready"},  32'(ld_ready),  32'(m_load));
        chk({tag, ".boot_done"}, 32'(boot_done), 32'(!m_load));
        chk({tag, ".ld_cnt"},    32'(ld_cnt),    32'(m_cnt));
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(m_rv));
        chk({tag, ".rsp_err"},   32'(rsp_err),   32'(m_re));
        if (m_rdk) chk({tag, ".rsp_data"}, rsp_data, m_rd);
    endtask

    // One clock cycle: drive inputs, check req_ready, advance model, check outputs.
    task automatic cyc(input bit lv, input int la, input logic [31:0] ldd, input bit ll,
                       input bit qv, input logic [31:0] qa, input bit pr);
        bit rr;
        bit err;
        int idx;
        ld_valid  = lv;
        ld_addr   = IDX_W'(la);
        ld_data   = ldd;
        ld_last   = ll;
        req_valid = qv;
        req_addr  = qa;
        rsp_ready = pr;
        #1;
        rr = !m_load && (!m_rv || pr);
        chk("req_ready", 32'(req_ready), 32'(rr));
        if (m_load) begin
            if (lv) begin
                m_mem[la] = ldd;
                m_kn[la]  = 1'b1;
                if (m_cnt < DEPTH) m_cnt++;
                if (ll) m_load = 1'b0;
            end
        end else if (qv && rr) begin
            err = (qa % 4 != 0) || (qa >= 32'(4 * DEPTH));
            idx = int'(qa / 4) % DEPTH;
            m_rv = 1'b1;
            m_re = err;
            if (err) begin
                m_rd  = 32'h0;
                m_rdk = 1'b1;
            end else begin
                m_rd  = m_mem[idx];
                m_rdk = m_kn[idx];
            end
        end else if (m_rv && pr) begin
            m_rv = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_state("cyc");
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        chk_state("reset");
        chk("reset.req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        for (int i = 0; i < DEPTH; i++) m_kn[i] = 1'b0;
        ld_valid = 0; ld_addr = '0; ld_data = '0; ld_last = 0;
        req_valid = 0; req_addr = '0; rsp_ready = 1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Load four words, last on idx 3.
        for (int i = 0; i < 4; i++) cyc(1, i, 32'hA000_0000 + 32'(i), i == 3, 0, 0, 1);
        chk("boot.ld_cnt", 32'(ld_cnt), 32'd4);
        chk("boot.done", 32'(boot_done), 32'd1);
        chk("boot.ld_ready", 32'(ld_ready), 32'd0);

        // Back-to-back fetches, one response per cycle.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, 32'(4 * i), 1);
            chk("fetch.data", rsp_data, 32'hA000_0000 + 32'(i));
            chk("fetch.err", 32'(rsp_err), 32'd0);
        end

        // Misaligned and out-of-range fetches.
        cyc(0, 0, 0, 0, 1, 32'h6, 1);
        chk("mis.err", 32'(rsp_err), 32'd1);
        chk("mis.data", rsp_data, 32'h0);
        cyc(0, 0, 0, 0, 1, 32'h1000, 1);
        chk("oor.err", 32'(rsp_err), 32'd1);
        chk("oor.data", rsp_data, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("retire.valid", 32'(rsp_valid), 32'd0);

        // Backpressure holds the response and blocks new requests.
        cyc(0, 0, 0, 0, 1, 32'h4, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1, 32'h8, 0);
            chk("hold.data", rsp_data, 32'hA000_0001);
        end
        cyc(0, 0, 0, 0, 1, 32'h8, 1);
        chk("release.data", rsp_data, 32'hA000_0002);

        // Reset with a response pending; array contents survive.
        chk("pre_rst.valid", 32'(rsp_valid), 32'd1);
        do_reset();
        chk("rst.valid", 32'(rsp_valid), 32'd0);
        chk("rst.boot", 32'(boot_done), 32'd0);
        cyc(1, 0, 32'hA000_0000, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 32'h4, 1);
        chk("retain.data", rsp_data, 32'hA000_0001);

        // Load port ignored while serving.
        cyc(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1);
        cyc(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 32'h0, 1);
        chk("ignore.data", rsp_data, 32'hA000_0000);
        chk("ignore.cnt", 32'(ld_cnt), 32'd1);

        // ld_last without ld_valid does not finish loading.
        do_reset();
        cyc(0, 5, 32'h1234_5678, 1, 0, 0, 1);
        chk("lastnv.boot", 32'(boot_done), 32'd0);

        // Randomized full-image load with gaps and rewrites; count saturates.
        for (int i = 0; i < DEPTH; i++) begin
            while ($urandom_range(0, 3) == 0)
                cyc(0, int'($urandom_range(0, DEPTH - 1)), $urandom, 1'($urandom), 0, 0, 1);
            cyc(1, i, $urandom, 0, 0, 0, 1);
        end
        for (int i = 0; i < 5; i++) cyc(1, int'($urandom_range(0, DEPTH - 1)), $urandom, 0, 0, 0, 1);
        cyc(1, int'($urandom_range(0, DEPTH - 1)), $urandom, 1, 0, 0, 1);
        chk("sat.ld_cnt", 32'(ld_cnt), 32'(DEPTH));

        // Randomized fetch traffic with backpressure and stray load pulses.
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = $urandom;
            else if (sel == 1) a = {$urandom_range(1, 255), 24'h0} | (32'($urandom_range(0, DEPTH - 1)) << 2);
            else               a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            cyc(1'($urandom_range(0, 7) == 0), int'($urandom_range(0, DEPTH - 1)), $urandom, 1'($urandom),
                1'($urandom_range(0, 3) != 0), a, $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder serving the fetch stage's read requests. After reset it accepts a program image word-by-word over a load port (replacing file-based preload). It then answers byte-addressed fetch requests with registered instruction words over a valid/ready handshake. It sits between the boot loader / testbench and the fetch stage, owning the 1024-word instruction store.

## Interface
- DEPTH, 1024, number of 32-bit instruction words (power of two)
- IDX_W, $clog2(DEPTH), word-index width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- ld_valid  in  1  load word present
- ld_ready  out  1  block accepts load words (LOAD state)
- ld_addr  in  IDX_W  word index to write
- ld_data  in  32  instruction word
- ld_last  in  1  final word of image, qualified by ld_valid
- ld_cnt  out  IDX_W+1  words written since reset, saturating at DEPTH
- boot_done  out  1  image loaded, serving fetches
- req_valid  in  1  fetch request present
- req_ready  out  1  request accepted this cycle when both high
- req_addr  in  32  byte address (PC)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  32  instruction word
- rsp_err  out  1  request was misaligned or out of range

## Operation
- Two states:
  - LOAD is the reset state.
  - SERVE is entered only from LOAD.
  - SERVE is left only by reset.
- LOAD:
  - ld_ready=1, req_ready=0.
  - Each ld_valid cycle writes mem[ld_addr]=ld_data and increments ld_cnt, saturating at DEPTH. Rewriting the same index still counts.
  - ld_valid && ld_last writes that word, then moves to SERVE.
- SERVE:
  - ld_ready=0; ld_* are ignored and cause no writes.
  - boot_done=1.
  - req_ready = !rsp_valid || rsp_ready.
- Request accept (req_valid && req_ready):
  - Response register loads on the same edge.
  - idx = req_addr[IDX_W+1:2].
  - err = (req_addr[1:0]!=0) || (req_addr[31:IDX_W+2]!=0).
  - rsp_data = err ? 32'h0 : mem[idx]; rsp_err = err; rsp_valid = 1.
- Response hold: while rsp_valid && !rsp_ready, rsp_data and rsp_err are frozen and no new request is accepted.
- Response retire: rsp_valid && rsp_ready with no new accept clears rsp_valid the next edge. rsp_data keeps its last value.
- Simultaneous retire and accept: the new response replaces the old one on that same edge, giving a full-throughput pipeline.
- Memory array has no reset. Contents survive rst; only control state is cleared.

## Timing
- Reset values (async, immediate on rst=0):
  - state=LOAD, ld_ready=1, ld_cnt=0, boot_done=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
- Load write: mem is updated at the ld_valid edge.
- LOAD→SERVE: boot_done rises in the cycle after the ld_last handshake, and req_ready can be 1 in that same cycle.
- Fetch latency: exactly 1 cycle from the accept edge to rsp_valid=1.
- Throughput: 1 response per cycle while rsp_ready=1.
- Reset mid-operation:
  - Any pending response is dropped (rsp_valid=0).
  - A partially loaded image remains in the array, but ld_cnt restarts at 0.
  - The block returns to LOAD and requires a new ld_last before serving again.
- ld_last on a cycle with ld_valid=0 has no effect.
- Back-to-back: ld_last handshake followed the next cycle by a req is legal. The request is accepted in the first SERVE cycle.

## Structure
- Shared package imem_pkg:
  - IMEM_DEPTH = 1024
  - IMEM_IDX_W
  - typedef enum logic {IMEM_LOAD, IMEM_SERVE} imem_state_t
  - NOP word constant 32'h0 used for error responses
- Sub-module imem_ram:
  - One synchronous write port, one synchronous registered read port.
  - No reset on storage.
  - The responder holds the FSM, ld_cnt, handshake and error logic, and uses the read-enable to implement the hold.

## Test plan
- Reset then load 4 words 0xA0000000..0xA0000003 at idx 0..3, last on idx 3 → ld_cnt=4; boot_done=1 one cycle after; ld_ready=0.
- SERVE with rsp_ready=1, requests at 0x0, 0x4, 0x8, 0xC on consecutive cycles → rsp_data 0xA0000000..0xA0000003 on the next 4 consecutive cycles, rsp_err=0.
- Request 0x6 and request 0x00001000 → rsp_err=1 and rsp_data=0 for both.
- Backpressure:
  - Stimulus: request 0x4 accepted, then rsp_ready=0 for 3 cycles with req_valid=1 at 0x8.
  - Required response: rsp_data stays 0xA0000001 and req_ready=0 throughout. After rsp_ready=1, the next cycle shows 0xA0000002.
- Reset asserted mid-stream with rsp_valid=1:
  - Required response: rsp_valid drops immediately and boot_done=0.
  - Reload only idx 0 with ld_last → fetch 0x4 still returns 0xA0000001 (array retained).
- ld_valid pulses during SERVE with ld_data 0xFFFFFFFF at idx 0 → fetch 0x0 still returns 0xA0000000; ld_cnt unchanged.
